// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the seven-segment display and the UART front end.
package seven_seg_pkg;

    // Glyphs, active-low, bit order .gfedcba (bit 7 = decimal point)
    localparam logic [7:0] SEG_0   = 8'hC0;
    localparam logic [7:0] SEG_1   = 8'hF9;
    localparam logic [7:0] SEG_2   = 8'hA4;
    localparam logic [7:0] SEG_3   = 8'hB0;
    localparam logic [7:0] SEG_4   = 8'h99;
    localparam logic [7:0] SEG_5   = 8'h92;
    localparam logic [7:0] SEG_6   = 8'h82;
    localparam logic [7:0] SEG_7   = 8'hF8;
    localparam logic [7:0] SEG_8   = 8'h80;
    localparam logic [7:0] SEG_9   = 8'h90;
    localparam logic [7:0] SEG_A   = 8'h88;
    localparam logic [7:0] SEG_B   = 8'h83;
    localparam logic [7:0] SEG_C   = 8'hC6;
    localparam logic [7:0] SEG_D   = 8'hA1;
    localparam logic [7:0] SEG_E   = 8'h86;
    localparam logic [7:0] SEG_F   = 8'h8E;
    localparam logic [7:0] SEG_DOT = 8'h7F;

    // Control characters understood by the decoder
    localparam logic [7:0] ASC_ESC = 8'h1B;
    localparam logic [7:0] ASC_DOT = 8'h2E;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble);
        case (nibble)
            4'h0:    return SEG_0;
            4'h1:    return SEG_1;
            4'h2:    return SEG_2;
            4'h3:    return SEG_3;
            4'h4:    return SEG_4;
            4'h5:    return SEG_5;
            4'h6:    return SEG_6;
            4'h7:    return SEG_7;
            4'h8:    return SEG_8;
            4'h9:    return SEG_9;
            4'hA:    return SEG_A;
            4'hB:    return SEG_B;
            4'hC:    return SEG_C;
            4'hD:    return SEG_D;
            4'hE:    return SEG_E;
            default: return SEG_F;
        endcase
    endfunction

    // True for '0'-'9', 'A'-'F', 'a'-'f'
    function automatic logic is_hex_char(input logic [7:0] c);
        return (c >= 8'h30 && c <= 8'h39) ||
               (c >= 8'h41 && c <= 8'h46) ||
               (c >= 8'h61 && c <= 8'h66);
    endfunction

    // Nibble value of a character already known to be hex; letters share low bits 1..6
    function automatic logic [3:0] hex_char_value(input logic [7:0] c);
        if (c <= 8'h39) begin
            return c[3:0];
        end
        return c[3:0] + 4'd9;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, falling-edge start detect, mid-bit sampling.
module uart_rx
    import seven_seg_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] data,
    output logic       byte_valid
);

    localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             fall;

    assign fall = rx_prev_q & ~rx_sync_q;

    // State register: synchronizer, FSM state and receive datapath
    always_ff @(posedge clk) begin
        // NOTE: every sequential assignment is non-blocking so all flops sample pre-edge values.
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    // Next-state logic: bit timing, glitch rejection and LSB-first shifting
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal unassigned (no latch).
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (fall) state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // Outputs: one-cycle strobe on a good stop bit; a low stop bit drops the byte
    always_comb begin
        byte_valid = (state_q == RX_STOP) && (cnt_q == BIT_LAST) && rx_sync_q;
        data       = shift_q;
    end

endmodule

// File: rtl/uart_hex_display.sv
// Host hex text over UART onto the multiplexed 4-digit seven-segment display.
module uart_hex_display
    import seven_seg_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115200,
    parameter int SCAN_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       usb_rx,
    output logic       usb_tx,
    output logic [7:0] led,
    output logic [3:0] io_sel,
    output logic [7:0] io_seg
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [7:0]        led_q, led_d;
    logic [3:0][3:0]   digits_q, digits_d;
    logic [3:0]        dp_q, dp_d;
    logic [SCAN_W-1:0] scan_cnt_q;
    logic [1:0]        idx_q;
    logic [3:0]        sel_q, sel_d;
    logic [7:0]        seg_q, seg_d;
    logic [1:0]        digit_idx;
    logic              scan_tick;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx_i      (usb_rx),
        .data      (rx_data),
        .byte_valid(rx_valid)
    );

    assign usb_tx = 1'b1;
    assign led    = led_q;
    assign io_sel = sel_q;
    assign io_seg = seg_q;

    // Byte decode: hex shifts in a nibble, '.' marks digit0, ESC blanks everything
    always_comb begin
        led_d    = led_q;
        digits_d = digits_q;
        dp_d     = dp_q;
        if (rx_valid) begin
            led_d = rx_data;
            if (is_hex_char(rx_data)) begin
                digits_d = {digits_q[2:0], hex_char_value(rx_data)};
                dp_d     = '0;
            end else if (rx_data == ASC_DOT) begin
                dp_d[0] = 1'b1;
            end else if (rx_data == ASC_ESC) begin
                digits_d = '0;
                dp_d     = '0;
            end
        end
    end

    // Scan: index 0 shows the leftmost digit (digit3); the wrap of the prescaler is the tick
    always_comb begin
        scan_tick = &scan_cnt_q;
        digit_idx = 2'd3 - idx_q;
        sel_d     = ~(4'b1000 >> idx_q);
        seg_d     = hex_to_seg(digits_q[digit_idx]) & (dp_q[digit_idx] ? SEG_DOT : 8'hFF);
    end

    // Registers: decode state, free-running prescaler, and the display drivers on each tick
    always_ff @(posedge clk) begin
        if (rst) begin
            led_q      <= '0;
            digits_q   <= '0;
            dp_q       <= '0;
            scan_cnt_q <= '0;
            idx_q      <= '0;
            sel_q      <= 4'hF;
            seg_q      <= 8'hFF;
        end else begin
            led_q      <= led_d;
            digits_q   <= digits_d;
            dp_q       <= dp_d;
            scan_cnt_q <= scan_cnt_q + SCAN_W'(1);
            if (scan_tick) begin
                idx_q <= idx_q + 2'd1;
                sel_q <= sel_d;
                seg_q <= seg_d;
            end
        end
    end

endmodule

// File: tb/tb_uart_hex_display.sv
// Scoreboarded bench: received bytes checked by a monitor, display checked at scan slots.
module tb_uart_hex_display;
    import seven_seg_pkg::*;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 100_000;
    localparam int SCAN_W = 4;
    localparam int BITCLK = CLK_HZ / BAUD;

    logic       clk = 1'b0;
    logic       rst;
    logic       usb_rx;
    logic       usb_tx;
    logic [7:0] led;
    logic [3:0] io_sel;
    logic [7:0] io_seg;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] pend_byte;
    logic       pend = 1'b0;

    uart_hex_display #(
        .CLK_HZ(CLK_HZ),
        .BAUD  (BAUD),
        .SCAN_W(SCAN_W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .usb_rx(usb_rx),
        .usb_tx(usb_tx),
        .led   (led),
        .io_sel(io_sel),
        .io_seg(io_seg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every strobed byte must be the oldest expected one, and led follows next cycle
    initial begin
        forever begin
            @(negedge clk);
            if (pend) begin
                check("led_after_byte", 32'(led), 32'(pend_byte));
                pend = 1'b0;
            end
            if (dut.rx_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte_valid", 32'(dut.rx_data), 32'hFFFF_FFFF);
                end else begin
                    pend_byte = exp_q.pop_front();
                    check("rx_byte", 32'(dut.rx_data), 32'(pend_byte));
                    pend = 1'b1;
                end
            end
        end
    end

    task automatic send_bit(input logic v, input int clocks);
        usb_rx = v;
        repeat (clocks) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        if (stop) exp_q.push_back(b);
        send_bit(1'b0, BITCLK);
        for (int i = 0; i < 8; i++) send_bit(b[i], BITCLK);
        send_bit(stop, BITCLK);
        send_bit(1'b1, 4);
    endtask

    // Let any buffer change propagate through a full scan round
    task automatic settle();
        repeat (70) @(negedge clk);
    endtask

    task automatic check_scan(input string name, input logic [3:0] sel, input logic [7:0] seg);
        int n = 0;
        while (io_sel !== sel && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({name, "_sel"}, 32'(io_sel), 32'(sel));
        check({name, "_seg"}, 32'(io_seg), 32'(seg));
    endtask

    initial begin
        string s;
        usb_rx = 1'b1;
        rst    = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_io_sel", 32'(io_sel), 32'hF);
        check("reset_io_seg", 32'(io_seg), 32'hFF);
        check("reset_led", 32'(led), 32'h00);
        check("reset_usb_tx", 32'(usb_tx), 32'h1);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        check("pre_first_tick_sel", 32'(io_sel), 32'hF);
        @(posedge clk);
        @(negedge clk);
        check("first_tick_sel", 32'(io_sel), 32'h7);
        check("first_tick_seg", 32'(io_seg), 32'hC0);

        // Hex entry "12AF"
        s = "12AF";
        for (int i = 0; i < 4; i++) send_byte(s[i], 1'b1);
        settle();
        check_scan("hex_d3", 4'h7, 8'hF9);
        check_scan("hex_d2", 4'hB, 8'hA4);
        check_scan("hex_d1", 4'hD, 8'h88);
        check_scan("hex_d0", 4'hE, 8'h8E);
        check("hex_led", 32'(led), 32'h46);

        // Decimal point on digit0
        send_byte(ASC_DOT, 1'b1);
        settle();
        check_scan("dp_d0", 4'hE, 8'h0E);
        check_scan("dp_d1", 4'hD, 8'h88);

        // ESC blanks to zeros
        send_byte(ASC_ESC, 1'b1);
        settle();
        check_scan("esc_d3", 4'h7, 8'hC0);
        check_scan("esc_d2", 4'hB, 8'hC0);
        check_scan("esc_d1", 4'hD, 8'hC0);
        check_scan("esc_d0", 4'hE, 8'hC0);
        check("esc_led", 32'(led), 32'h1B);

        // Put a visible digit in so "unchanged" checks mean something
        send_byte(8'h37, 1'b1);
        settle();
        check_scan("seven_d0", 4'hE, 8'hF8);

        // Framing error: byte discarded
        send_byte(8'h35, 1'b0);
        check("frame_err_idle", 32'(dut.u_rx.state_q), 32'(RX_IDLE));
        check("frame_err_led", 32'(led), 32'h37);
        settle();
        check_scan("frame_err_d0", 4'hE, 8'hF8);
        check_scan("frame_err_d1", 4'hD, 8'hC0);

        // Non-hex byte: led only
        send_byte(8'h67, 1'b1);
        check("nonhex_led", 32'(led), 32'h67);
        settle();
        check_scan("nonhex_d0", 4'hE, 8'hF8);

        // Start-bit glitch of 3 clocks
        usb_rx = 1'b0;
        repeat (3) @(negedge clk);
        usb_rx = 1'b1;
        repeat (12) @(negedge clk);
        check("glitch_idle", 32'(dut.u_rx.state_q), 32'(RX_IDLE));
        check("glitch_led", 32'(led), 32'h67);

        // Reset during data bit 4 of '7' (bit 4 is 1, so the line is high at reset)
        send_bit(1'b0, BITCLK);
        for (int i = 0; i < 4; i++) send_bit(s[0][i] ^ 1'b0 ? 1'b1 : 1'b0, 0);
        for (int i = 0; i < 4; i++) send_bit((8'h37 >> i) & 8'h01 ? 1'b1 : 1'b0, BITCLK);
        send_bit(1'b1, 4);
        check("midframe_in_data", 32'(dut.u_rx.state_q), 32'(RX_DATA));
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("midframe_reset_led", 32'(led), 32'h00);
        check("midframe_reset_sel", 32'(io_sel), 32'hF);
        send_byte(8'h35, 1'b1);
        settle();
        check_scan("after_reset_d0", 4'hE, 8'h92);
        check_scan("after_reset_d1", 4'hD, 8'hC0);
        check_scan("after_reset_d3", 4'h7, 8'hC0);
        check("after_reset_led", 32'(led), 32'h35);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
